// File: rtl/booth_r4_seq_ctrl.sv
// rtl/booth_r4_seq_ctrl.sv - radix-4 Booth sequencer for a signed 8x8 multiply using a shared 9-bit adder
// Optional product accumulator enabled by defining MACC_ACCUM_EN.
module booth_r4_seq_ctrl #(
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a_in,
  input  logic [7:0]       b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      product,
  input  logic             acc_clr,
  output logic [ACC_W-1:0] acc_out,
  output logic [8:0]       adder_a,
  output logic [8:0]       adder_b,
  output logic             adder_cin,
  input  logic [9:0]       adder_sum
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  m_reg;
  logic [7:0]  q_reg;
  logic        q_m1;
  logic [8:0]  p_reg;
  logic [1:0]  iter;
  logic [15:0] product_reg;

  logic [2:0]  digit;
  logic [8:0]  m9, m2;
  logic [8:0]  mult;
  logic        neg;
  logic [9:0]  s10;
  logic [8:0]  p_new;
  logic [7:0]  q_new;

  assign digit = {q_reg[1:0], q_m1};
  assign m9    = {m_reg[7], m_reg};
  assign m2    = {m_reg, 1'b0};

  always_comb begin
    mult = '0;
    neg  = 1'b0;
    case (digit)
      3'b001, 3'b010: mult = m9;
      3'b011:         mult = m2;
      3'b100: begin
        mult = m2;
        neg  = 1'b1;
      end
      3'b101, 3'b110: begin
        mult = m9;
        neg  = 1'b1;
      end
      default: begin
        mult = '0;
        neg  = 1'b0;
      end
    endcase
  end

  // Adder is released to other users whenever we are not iterating.
  always_comb begin
    adder_a   = '0;
    adder_b   = '0;
    adder_cin = 1'b0;
    if (state == RUN) begin
      adder_a   = p_reg;
      adder_b   = neg ? ~mult : mult;
      adder_cin = neg;
    end
  end

  // Recover the true 10-bit signed sum from the 9-bit operands and carry out.
  assign s10   = {adder_a[8] ^ adder_b[8] ^ adder_sum[9], adder_sum[8:0]};
  assign p_new = {s10[9], s10[9:2]};
  assign q_new = {s10[1:0], q_reg[7:2]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (iter == 2'd3) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_reg       <= '0;
      q_reg       <= '0;
      q_m1        <= 1'b0;
      p_reg       <= '0;
      iter        <= '0;
      product_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            m_reg <= a_in;
            q_reg <= b_in;
            q_m1  <= 1'b0;
            p_reg <= '0;
            iter  <= '0;
          end
        end
        RUN: begin
          p_reg <= p_new;
          q_reg <= q_new;
          q_m1  <= q_reg[1];
          iter  <= iter + 2'd1;
          if (iter == 2'd3) product_reg <= {p_new[7:0], q_new};
        end
        default: ;
      endcase
    end
  end

  assign product = product_reg;

`ifdef MACC_ACCUM_EN
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_base;

  // A clear coinciding with an accumulate restarts from this product.
  assign acc_base = acc_clr ? '0 : acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (state == DONE && out_ready) begin
      acc <= acc_base + ACC_W'(signed'(product_reg));
    end else if (acc_clr) begin
      acc <= '0;
    end
  end

  assign acc_out = acc;
`else
  logic unused_acc_clr;
  assign unused_acc_clr = acc_clr;
  assign acc_out        = '0;
`endif

endmodule

// File: tb/tb_booth_r4_seq_ctrl.sv
// tb/tb_booth_r4_seq_ctrl.sv - directed vector bench for booth_r4_seq_ctrl
module tb_booth_r4_seq_ctrl;
  localparam int ACC_W = 20;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       a_in;
  logic [7:0]       b_in;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      product;
  logic             acc_clr;
  logic [ACC_W-1:0] acc_out;
  logic [8:0]       adder_a;
  logic [8:0]       adder_b;
  logic             adder_cin;
  logic [9:0]       adder_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign adder_sum = {1'b0, adder_a} + {1'b0, adder_b} + {9'd0, adder_cin};

  booth_r4_seq_ctrl #(.ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .acc_clr   (acc_clr),
    .acc_out   (acc_out),
    .adder_a   (adder_a),
    .adder_b   (adder_b),
    .adder_cin (adder_cin),
    .adder_sum (adder_sum)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
    int          hold;
    bit          chk_zero;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issues one product; junk operands are offered while busy to show they are ignored.
  task automatic do_mul(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                        input int hold, input bit chk_zero);
    int cycles;
    bit zero_ok;
    bit busy_ok;
    @(negedge clk);
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    a_in      = a;
    b_in      = b;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    cycles    = 0;
    zero_ok   = 1'b1;
    busy_ok   = 1'b1;
    @(negedge clk);
    cycles = 1;
    a_in   = ~a;
    b_in   = ~b;
    while (!out_valid && cycles < 20) begin
      if (in_ready) busy_ok = 1'b0;
      if (adder_b != 9'd0 || adder_cin) zero_ok = 1'b0;
      @(negedge clk);
      cycles++;
    end
    in_valid = 1'b0;
    check("out_valid_seen", {31'd0, out_valid}, 32'd1);
    check("latency", cycles, 32'd5);
    check("in_ready_busy", {31'd0, busy_ok}, 32'd1);
    check("product", {16'd0, product}, {16'd0, exp});
    check("adder_idle_done", {22'd0, adder_a, adder_cin}, 32'd0);
    if (chk_zero) check("zero_digit_adder", {31'd0, zero_ok}, 32'd1);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_product", {16'd0, product}, {16'd0, exp});
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("ready_after", {31'd0, in_ready}, 32'd1);
    check("valid_after", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int seen_valid;
    vecs[0] = '{8'd3, 8'd5, 16'd15, 0, 1'b0};
    vecs[1] = '{8'(-128), 8'(-128), 16'd16384, 0, 1'b0};
    vecs[2] = '{8'(-128), 8'd127, 16'(-16256), 0, 1'b0};
    vecs[3] = '{8'd127, 8'(-1), 16'(-127), 0, 1'b0};
    vecs[4] = '{8'h5A, 8'd0, 16'd0, 0, 1'b1};
    vecs[5] = '{8'd7, 8'd9, 16'd63, 3, 1'b0};
    vecs[6] = '{8'(-1), 8'(-1), 16'd1, 0, 1'b0};
    vecs[7] = '{8'd100, 8'(-100), 16'(-10000), 1, 1'b0};
    vecs[8] = '{8'(-57), 8'd83, 16'(-4731), 0, 1'b0};
    vecs[9] = '{8'd127, 8'd127, 16'd16129, 0, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    a_in      = '0;
    b_in      = '0;
    out_ready = 1'b0;
    acc_clr   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_product", {16'd0, product}, 32'd0);
    check("rst_acc", {12'd0, acc_out}, 32'd0);
    check("rst_adder", {22'd0, adder_a, adder_cin}, 32'd0);
    check("rst_adder_b", {23'd0, adder_b}, 32'd0);

    foreach (vecs[i]) do_mul(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].hold, vecs[i].chk_zero);

    // Reset during iteration 2 must abort the product.
    @(negedge clk);
    a_in     = 8'd3;
    b_in     = 8'd5;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrun_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrun_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrun_adder", {22'd0, adder_a, adder_cin}, 32'd0);
    check("midrun_adder_b", {23'd0, adder_b}, 32'd0);
    check("midrun_product", {16'd0, product}, 32'd0);
    seen_valid = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) seen_valid++;
    end
    check("midrun_no_valid", seen_valid, 32'd0);
    do_mul(8'd11, 8'(-13), 16'(-143), 0, 1'b0);

    @(negedge clk);
    acc_clr = 1'b1;
    @(negedge clk);
    acc_clr = 1'b0;
    check("acc_cleared", {12'd0, acc_out}, 32'd0);
    do_mul(8'd15, 8'd15, 16'd225, 0, 1'b0);
`ifdef MACC_ACCUM_EN
    check("acc_225", {12'd0, acc_out}, 32'd225);
`else
    check("acc_off_0", {12'd0, acc_out}, 32'd0);
`endif
    do_mul(8'(-3), 8'd4, 16'(-12), 0, 1'b0);
`ifdef MACC_ACCUM_EN
    check("acc_213", {12'd0, acc_out}, 32'd213);
`else
    check("acc_off_1", {12'd0, acc_out}, 32'd0);
`endif
    do_mul(8'd56, 8'd25, 16'd1400, 0, 1'b0);
`ifdef MACC_ACCUM_EN
    check("acc_1613", {12'd0, acc_out}, 32'd1613);
`else
    check("acc_off_2", {12'd0, acc_out}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
